// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
//
// Scans a ROWS x COLS keypad by driving one column low at a time. It reads the
// row lines back through a 2-flop synchronizer. Once per frame it reports the
// lowest-index pressed key, which is the first hit in ascending column/row
// order. The report feeds the key debouncer.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   scan_en      enables scanning; sampled only in IDLE and REPORT
//   row_n        row sense lines, active-low, asynchronous to clk
//   col_n        column drive, active-low one-hot while scanning, all ones otherwise
//   key_pressed  a key was seen in the last completed frame
//   key_id       reported key index = col*ROWS + row (0 when key_pressed=0)
//   frame_done   one-cycle pulse, high in the cycle key_pressed/key_id take new values
//   multi_key    (KEYPAD_MULTI_REJECT_EN only) two or more keys were seen in the last frame
//
// Optional build macro KEYPAD_MULTI_REJECT_EN: when two or more keys are seen in
// one frame, the report is suppressed (key_pressed=0, key_id=0) and multi_key=1.
//
// state  | meaning
// IDLE   | columns released, waiting for scan_en
// DRIVE  | current column driven low, letting the rows settle
// SAMPLE | current column still driven; synchronized rows are folded into the frame
// REPORT | columns released; the frame result is on the outputs and frame_done is high

module keypad_matrix_scanner #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int SETTLE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            scan_en,
  input  logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col_n,
  output logic            key_pressed,
  output logic [4:0]      key_id,
`ifdef KEYPAD_MULTI_REJECT_EN
  output logic            multi_key,
`endif
  output logic            frame_done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW = $clog2(SETTLE);
  localparam logic [4:0] ROWS5 = 5'(ROWS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] REPORT = 2'd3;

  generate
    if (ROWS * COLS > 32 || SETTLE < 3) begin : g_param_check
      $error("keypad_matrix_scanner: requires ROWS*COLS <= 32 and SETTLE >= 3");
    end
  endgenerate

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [ROWS-1:0] row_s1_q, row_s2_q;
  logic            hit_q, hit_d;
  logic [4:0]      best_q, best_d;
  logic            key_pressed_q, key_pressed_d;
  logic [4:0]      key_id_q, key_id_d;
  logic [COLS-1:0] col_n_q, col_n_d;

  logic [ROWS-1:0] row_hit;
  logic            any_row;
  logic [4:0]      low_idx;

`ifdef KEYPAD_MULTI_REJECT_EN
  logic [1:0]      hcnt_q, hcnt_d;
  logic            multi_q, multi_d;
  logic [5:0]      nrow;
  logic [6:0]      hcnt_sum;
  logic [1:0]      hcnt_nx;
`endif

  // Hits in the column currently being sampled. The loop runs from the top row
  // down, so the lowest pressed row is the one that remains in low_idx.
  always_comb begin
    row_hit = ~row_s2_q;
    any_row = |row_hit;
    low_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (row_hit[r]) low_idx = 5'(col_q) * ROWS5 + 5'(r);
    end
`ifdef KEYPAD_MULTI_REJECT_EN
    nrow = '0;
    for (int r = 0; r < ROWS; r++) begin
      nrow = nrow + 6'(row_hit[r]);
    end
    // The hit count saturates at 2. Only "none / one / several" matters.
    hcnt_sum = 7'(hcnt_q) + 7'(nrow);
    hcnt_nx  = (hcnt_sum >= 7'd2) ? 2'd2 : hcnt_sum[1:0];
`endif
  end

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    settle_d      = settle_q;
    hit_d         = hit_q;
    best_d        = best_q;
    key_pressed_d = key_pressed_q;
    key_id_d      = key_id_q;
`ifdef KEYPAD_MULTI_REJECT_EN
    hcnt_d        = hcnt_q;
    multi_d       = multi_q;
`endif

    case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d  = DRIVE;
          col_d    = '0;
          settle_d = '0;
        end
      end
      DRIVE: begin
        if (settle_q == SW'(SETTLE - 1)) state_d = SAMPLE;
        else                             settle_d = settle_q + SW'(1);
      end
      SAMPLE: begin
        hit_d = hit_q | any_row;
        // The first column with a hit fixes the index for the rest of the frame.
        if (!hit_q && any_row) best_d = low_idx;
`ifdef KEYPAD_MULTI_REJECT_EN
        hcnt_d = hcnt_nx;
`endif
        if (col_q == CW'(COLS - 1)) begin
          state_d = REPORT;
          // The outputs load on the edge into REPORT. That makes them change
          // in the same cycle that frame_done is high.
          key_pressed_d = hit_d;
          key_id_d      = hit_d ? best_d : 5'd0;
`ifdef KEYPAD_MULTI_REJECT_EN
          multi_d = (hcnt_nx == 2'd2);
          if (hcnt_nx == 2'd2) begin
            key_pressed_d = 1'b0;
            key_id_d      = 5'd0;
          end
`endif
        end else begin
          state_d  = DRIVE;
          col_d    = col_q + CW'(1);
          settle_d = '0;
        end
      end
      default: begin
        hit_d    = 1'b0;
        best_d   = '0;
        col_d    = '0;
        settle_d = '0;
`ifdef KEYPAD_MULTI_REJECT_EN
        hcnt_d   = '0;
`endif
        state_d  = scan_en ? DRIVE : IDLE;
      end
    endcase

    // The column drive is registered from the next state, so col_n has no
    // decode glitches on the keypad pins.
    if (state_d == DRIVE || state_d == SAMPLE) col_n_d = ~(COLS'(1) << col_d);
    else                                       col_n_d = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      col_q         <= '0;
      settle_q      <= '0;
      row_s1_q      <= '1;
      row_s2_q      <= '1;
      hit_q         <= 1'b0;
      best_q        <= '0;
      key_pressed_q <= 1'b0;
      key_id_q      <= '0;
      col_n_q       <= '1;
`ifdef KEYPAD_MULTI_REJECT_EN
      hcnt_q        <= '0;
      multi_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      settle_q      <= settle_d;
      row_s1_q      <= row_n;
      row_s2_q      <= row_s1_q;
      hit_q         <= hit_d;
      best_q        <= best_d;
      key_pressed_q <= key_pressed_d;
      key_id_q      <= key_id_d;
      col_n_q       <= col_n_d;
`ifdef KEYPAD_MULTI_REJECT_EN
      hcnt_q        <= hcnt_d;
      multi_q       <= multi_d;
`endif
    end
  end

  assign col_n       = col_n_q;
  assign key_pressed = key_pressed_q;
  assign key_id      = key_id_q;
  assign frame_done  = (state_q == REPORT);
`ifdef KEYPAD_MULTI_REJECT_EN
  assign multi_key   = multi_q;
`endif

endmodule
